shift_add_mult_ctrl: RTL and testbench

- Sequencer that runs an unsigned N×N shift-and-add multiply through the team's shared 16-bit combinational adder ALU (operands A, P; output Result = A + P).
- Owns the operand registers, the accumulator and the iteration counter. Drives the ALU inputs each cycle and writes the ALU result back into the accumulator.
- Sits between the top-level control/IO logic (start/done handshake) and the adder instance; the adder is instantiated outside this block.

---
 rtl/shift_add_mult_ctrl.sv | 131 +++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequencer for an unsigned WIDTH x WIDTH shift-and-add multiply carried out
// through an external 2*WIDTH-bit combinational adder (Result = A + P).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        request pulse, honoured only in IDLE
//   multiplicand_i operand X, latched when start is accepted
//   multiplier_i   operand Y, latched when start is accepted
//   alu_a_o        to adder A: current accumulator (0 outside RUN)
//   alu_p_o        to adder P: current partial product (0 outside RUN)
//   alu_result_i   from adder Result
//   product_o      final X*Y, held until the next operation completes or reset
//   busy_o         high while the multiply is running
//   done_o         one-cycle pulse when product_o becomes valid
//
// WIDTH must be 8 so that 2*WIDTH matches the 16-bit shared adder.

module shift_add_mult_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     multiplicand_i,
   input  logic [WIDTH-1:0]     multiplier_i,
   output logic [2*WIDTH-1:0]   alu_a_o,
   output logic [2*WIDTH-1:0]   alu_p_o,
   input  logic [2*WIDTH-1:0]   alu_result_i,
   output logic [2*WIDTH-1:0]   product_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [2*WIDTH-1:0] x_ext;

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      x_d       = x_q;
      y_d       = y_q;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               x_d     = multiplicand_i;
               y_d     = multiplier_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            acc_d = alu_result_i;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntMax) begin
               product_d = alu_result_i;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // busy/done are registered copies of the next state so they come straight off flops
      busy_d = (state_d == StRun);
      done_d = (state_d == StDone);
   end

   // Adder operands: only state and internal registers feed these, never alu_result_i
   assign x_ext = {{WIDTH{1'b0}}, x_q};

   always_comb begin
      alu_a_o = '0;
      alu_p_o = '0;
      if (state_q == StRun) begin
         alu_a_o = acc_q;
         if (y_q[cnt_q]) begin
            alu_p_o = x_ext << cnt_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         x_q       <= x_d;
         y_q       <= y_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign product_o = product_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl. Models the external adder and checks the sequencer against
// a plain-arithmetic reference (X*Y, per-bit partial products, timing of busy/done).

module tb_shift_add_mult_ctrl;

   localparam int unsigned W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] alu_a;
   logic [2*W-1:0] alu_p;
   logic [2*W-1:0] alu_result;
   logic [2*W-1:0] product;
   logic           busy;
   logic           done;

   int total;
   int bad;

   shift_add_mult_ctrl #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start),
      .multiplicand_i (mcand),
      .multiplier_i   (mplier),
      .alu_a_o        (alu_a),
      .alu_p_o        (alu_p),
      .alu_result_i   (alu_result),
      .product_o      (product),
      .busy_o         (busy),
      .done_o         (done)
   );

   // External shared adder
   assign alu_result = alu_a + alu_p;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: partial product contributed by multiplier bit k
   function automatic int unsigned ref_partial(int unsigned x, int unsigned y, int k);
      if (((y >> k) & 1) != 0) return (x << k) & 32'hFFFF;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      mcand = '0;
      mplier = '0;
      #12;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0 || alu_a !== 16'h0 ||
          alu_p !== 16'h0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b product=%h alu_a=%h alu_p=%h want all 0",
                  busy, done, product, alu_a, alu_p);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      total++;
      if (busy !== 1'b0 || alu_p !== 16'h0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b alu_p=%h want 0/0000", busy, alu_p);
      end
   endtask

   // One complete operation with per-cycle checks of busy, done, alu_a and alu_p
   task automatic test_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned acc;
      int unsigned exp_prod;
      exp_prod = int'(x) * int'(y);
      acc = 0;
      @(negedge clk);
      mcand = x;
      mplier = y;
      start = 1'b1;
      tick();  // accepting edge
      start = 1'b0;
      mcand = $urandom;
      mplier = $urandom;
      for (int k = 0; k < int'(W); k++) begin
         total++;
         if (busy !== 1'b1 || done !== 1'b0 || alu_a !== acc[15:0] ||
             alu_p !== 16'(ref_partial(x, y, k))) begin
            bad++;
            $display("FAIL %s run_cycle%0d: busy=%b done=%b alu_a=%h alu_p=%h want 1 0 %h %h",
                     name, k, busy, done, alu_a, alu_p, acc[15:0], ref_partial(x, y, k));
         end
         acc = acc + ref_partial(x, y, k);
         tick();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || product !== 16'(exp_prod) || alu_p !== 16'h0) begin
         bad++;
         $display("FAIL %s done_cycle: done=%b busy=%b product=%h alu_p=%h want 1 0 %h 0000",
                  name, done, busy, product, alu_p, exp_prod[15:0]);
      end
      tick();
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 16'(exp_prod)) begin
         bad++;
         $display("FAIL %s hold: done=%b busy=%b product=%h want 0 0 %h",
                  name, done, busy, product, exp_prod[15:0]);
      end
   endtask

   task automatic test_max_last_partial();
      // Last RUN cycle with X=Y=255 drives 255<<7
      @(negedge clk);
      mcand = 8'hFF;
      mplier = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < int'(W) - 1; k++) tick();
      total++;
      if (alu_p !== 16'h7F80) begin
         bad++;
         $display("FAIL max_last_alu_p: got %h want 7f80", alu_p);
      end
      tick();
      total++;
      if (product !== 16'hFE01 || done !== 1'b1) begin
         bad++;
         $display("FAIL max_product: product=%h done=%b want fe01 1", product, done);
      end
      tick();
   endtask

   task automatic test_start_during_busy();
      int dones;
      @(negedge clk);
      mcand = 8'd3;
      mplier = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 4) begin
            mcand = 8'd7;
            mplier = 8'd7;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 1 || product !== 16'h000F || busy !== 1'b0) begin
         bad++;
         $display("FAIL start_during_busy: dones=%0d product=%h busy=%b want 1 000f 0",
                  dones, product, busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int dones;
      @(negedge clk);
      mcand = 8'd200;
      mplier = 8'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid_op: busy=%b done=%b product=%h want 0 0 0000",
                  busy, done, product);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++;
      if (dones != 0 || product !== 16'h0) begin
         bad++;
         $display("FAIL idle_after_abort: activity=%0d product=%h want 0 0000", dones, product);
      end
   endtask

   task automatic test_back_to_back();
      int last;
      int pulses;
      @(negedge clk);
      mcand = 8'd2;
      mplier = 8'd9;
      start = 1'b1;
      last = -1;
      pulses = 0;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (done === 1'b1) begin
            pulses++;
            total++;
            if (product !== 16'h0012 || (last >= 0 && c - last != int'(W) + 2)) begin
               bad++;
               $display("FAIL back_to_back: product=%h gap=%0d want 0012 %0d",
                        product, c - last, W + 2);
            end
            last = c;
         end
      end
      start = 1'b0;
      total++;
      if (pulses < 4) begin
         bad++;
         $display("FAIL back_to_back_count: pulses=%0d want >=4", pulses);
      end
      for (int c = 0; c < 12; c++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         test_op("random", W'($urandom), W'($urandom));
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_op("single_13x11", 8'd13, 8'd11);
      test_op("max", 8'hFF, 8'hFF);
      test_max_last_partial();
      test_op("zero_y", 8'hA5, 8'h00);
      test_op("zero_x", 8'h00, 8'h77);
      test_start_during_busy();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
